// File: rtl/beta_irq_ctrl_pkg.sv
// Shared definitions for the BETA interrupt controller: register offsets,
// CLAIM word layout and the default register window base.
package beta_irq_ctrl_pkg;

    typedef enum logic [2:0] {
        IRQ_PEND  = 3'd0,
        IRQ_MASK  = 3'd1,
        IRQ_EDGE  = 3'd2,
        IRQ_CLAIM = 3'd3,
        IRQ_EOI   = 3'd4,
        IRQ_INSRV = 3'd5
    } irq_reg_e;

    localparam int unsigned CLAIM_VALID_BIT  = 31;
    localparam int unsigned IRQ_ID_W         = 5;
    localparam int unsigned IRQ_MAX_SRC      = 16;
    localparam logic [31:0] IRQ_BASE_DEFAULT = 32'hFFFF_FF00;

    typedef struct packed {
        logic                valid;
        logic [IRQ_ID_W-1:0] id;
    } claim_t;

endpackage

// File: rtl/beta_irq_ctrl_sync2.sv
// W-wide two-flop synchronizer for asynchronous interrupt sources.
module beta_sync2 #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/beta_irq_ctrl.sv
// Interrupt controller feeding the BETA core IRQ input: per-source edge/level
// capture, mask, fixed priority (index 0 highest), claim/EOI register handshake.
module beta_irq_ctrl
    import beta_irq_ctrl_pkg::*;
#(
    parameter int unsigned NSRC      = 8,
    parameter logic [31:0] BASE_ADDR = IRQ_BASE_DEFAULT
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [NSRC-1:0] SRC,
    input  logic [31:0]     MA,
    input  logic            MOE,
    input  logic            MWR,
    input  logic [31:0]     MWD,
    output logic [31:0]     RDATA,
    output logic            HIT,
    output logic            IRQ
);

    if (NSRC < 1 || NSRC > IRQ_MAX_SRC) begin : g_nsrc_check
        $error("beta_irq_ctrl: NSRC must be in 1..16");
    end

    function automatic claim_t f_prio(input logic [NSRC-1:0] v);
        claim_t c;
        c = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (v[i] && !c.valid) begin
                c.valid = 1'b1;
                c.id    = IRQ_ID_W'(i);
            end
        end
        return c;
    endfunction

    logic [NSRC-1:0] w_s2;
    logic [NSRC-1:0] r_s3;
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_edge;
    logic [NSRC-1:0] r_insrv;
    logic            r_irq;

    logic            w_hit;
    logic [2:0]      w_off;
    logic            w_wr;
    logic            w_rd;
    logic [NSRC-1:0] w_active;
    claim_t          w_claim;
    logic            w_claim_go;
    logic [NSRC-1:0] w_claim_oh;
    logic [NSRC-1:0] w_w1c;
    logic [NSRC-1:0] w_eoi_oh;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_pend_nxt;
    logic [NSRC-1:0] w_insrv_nxt;
    logic            w_irq_nxt;
    logic            w_unused;

    beta_sync2 #(
        .W (NSRC)
    ) u_sync (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_d     (SRC),
        .o_q     (w_s2)
    );

    assign w_hit = (MA[31:5] == BASE_ADDR[31:5]);
    assign w_off = MA[4:2];
    assign w_wr  = w_hit & MWR;
    assign w_rd  = w_hit & MOE & ~MWR;

    assign w_active   = r_pend & r_mask;
    assign w_claim    = f_prio(w_active);
    assign w_claim_go = w_rd && (w_off == IRQ_CLAIM) && w_claim.valid;
    assign w_rise     = w_s2 & ~r_s3;

    always_comb begin
        w_claim_oh = '0;
        w_w1c      = '0;
        w_eoi_oh   = '0;
        if (w_claim_go) begin
            w_claim_oh = NSRC'(1) << w_claim.id;
        end
        if (w_wr && w_off == IRQ_PEND) begin
            w_w1c = MWD[NSRC-1:0];
        end
        // ids >= NSRC shift out to zero, so out-of-range EOIs are dropped naturally
        if (w_wr && w_off == IRQ_EOI) begin
            w_eoi_oh = NSRC'(1) << MWD[IRQ_ID_W-1:0];
        end
    end

    // Edge sources: a new rise wins over W1C/claim clears; level sources track s2.
    assign w_pend_nxt  = (r_edge & ((r_pend & ~w_w1c & ~w_claim_oh) | w_rise))
                       | (~r_edge & w_s2);
    assign w_insrv_nxt = (r_insrv & ~w_eoi_oh) | w_claim_oh;
    assign w_irq_nxt   = (|w_active) & ~(|r_insrv);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_s3    <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_edge  <= '0;
            r_insrv <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_s3    <= w_s2;
            r_pend  <= w_pend_nxt;
            r_insrv <= w_insrv_nxt;
            r_irq   <= w_irq_nxt;
            if (w_wr && w_off == IRQ_MASK) begin
                r_mask <= MWD[NSRC-1:0];
            end
            if (w_wr && w_off == IRQ_EDGE) begin
                r_edge <= MWD[NSRC-1:0];
            end
        end
    end

    always_comb begin
        RDATA = '0;
        if (w_hit) begin
            case (w_off)
                IRQ_PEND:  RDATA = 32'(r_pend);
                IRQ_MASK:  RDATA = 32'(r_mask);
                IRQ_EDGE:  RDATA = 32'(r_edge);
                IRQ_CLAIM: begin
                    RDATA[CLAIM_VALID_BIT]  = w_claim.valid;
                    RDATA[IRQ_ID_W-1:0]     = w_claim.id;
                end
                IRQ_INSRV: RDATA = 32'(r_insrv);
                default:   RDATA = '0;
            endcase
        end
    end

    assign HIT = w_hit;
    assign IRQ = r_irq;

    assign w_unused = &{1'b0, MA[1:0], MWD};

endmodule

// File: tb/tb_beta_irq_ctrl.sv
// Directed self-checking bench for beta_irq_ctrl (NSRC=8, default base).
module tb_beta_irq_ctrl;
    import beta_irq_ctrl_pkg::*;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic        CLK     = 1'b0;
    logic        RESET_N = 1'b0;
    logic [7:0]  SRC     = '0;
    logic [31:0] MA      = '0;
    logic        MOE     = 1'b0;
    logic        MWR     = 1'b0;
    logic [31:0] MWD     = '0;
    logic [31:0] RDATA;
    logic        HIT;
    logic        IRQ;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    beta_irq_ctrl #(
        .NSRC      (8),
        .BASE_ADDR (BASE)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .SRC     (SRC),
        .MA      (MA),
        .MOE     (MOE),
        .MWR     (MWR),
        .MWD     (MWD),
        .RDATA   (RDATA),
        .HIT     (HIT),
        .IRQ     (IRQ)
    );

    typedef struct {
        logic [31:0] ma;
        logic        moe;
        logic        mwr;
        logic [31:0] mwd;
        logic        exp_hit;
        logic        chk_rd;
        logic [31:0] exp_rd;
        string       name;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        MA  = BASE + {27'b0, off, 2'b00};
        MWD = d;
        MWR = 1'b1;
        tick();
        MWR = 1'b0;
    endtask

    task automatic chk_rd(input logic [2:0] off, input logic [31:0] exp, input string nm);
        logic [31:0] d;
        MA  = BASE + {27'b0, off, 2'b00};
        MOE = 1'b1;
        #1;
        d = RDATA;
        check(nm, d, exp);
        tick();
        MOE = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{BASE + 32'h00, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,  "rst_pend"};
        vecs[1]  = '{BASE + 32'h04, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,  "rst_mask"};
        vecs[2]  = '{BASE + 32'h08, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,  "rst_edge"};
        vecs[3]  = '{BASE + 32'h14, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,  "rst_insrv"};
        vecs[4]  = '{BASE + 32'h0C, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,  "rst_claim"};
        vecs[5]  = '{BASE + 32'h04, 1'b0, 1'b1, 32'hFFFF_FF5A, 1'b1, 1'b0, 32'h0,  "wr_mask"};
        vecs[6]  = '{BASE + 32'h04, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h5A, "rd_mask"};
        vecs[7]  = '{BASE + 32'h08, 1'b0, 1'b1, 32'h0000_003C, 1'b1, 1'b0, 32'h0,  "wr_edge"};
        vecs[8]  = '{BASE + 32'h08, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h3C, "rd_edge"};
        vecs[9]  = '{BASE + 32'h1C, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0,  "wr_off7"};
        vecs[10] = '{BASE + 32'h1C, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,  "rd_off7"};
        vecs[11] = '{BASE + 32'h18, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,  "rd_off6"};
        vecs[12] = '{BASE + 32'h10, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,  "rd_eoi"};
        vecs[13] = '{BASE + 32'h20, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,  "miss_base32"};
        vecs[14] = '{BASE - 32'h04, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,  "miss_below"};
        vecs[15] = '{32'h0000_0004, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,  "miss_low"};

        #23 RESET_N = 1'b1;
        tick();
        check1("rst_irq", IRQ, 1'b0);

        for (int i = 0; i < 16; i++) begin
            MA  = vecs[i].ma;
            MOE = vecs[i].moe;
            MWR = vecs[i].mwr;
            MWD = vecs[i].mwd;
            #1;
            check1({vecs[i].name, "_hit"}, HIT, vecs[i].exp_hit);
            if (vecs[i].chk_rd) check(vecs[i].name, RDATA, vecs[i].exp_rd);
            tick();
            MOE = 1'b0;
            MWR = 1'b0;
        end

        // Edge path and latency
        wr(IRQ_MASK, 32'hFF);
        wr(IRQ_EDGE, 32'hFF);
        SRC = 8'h08;
        ticks(3);
        check1("irq_lat3", IRQ, 1'b0);
        tick();
        check1("irq_lat4", IRQ, 1'b1);
        chk_rd(IRQ_CLAIM, 32'h8000_0003, "claim3");
        check1("irq_claim_edge", IRQ, 1'b1);
        tick();
        check1("irq_drop", IRQ, 1'b0);
        chk_rd(IRQ_INSRV, 32'h08, "insrv3");
        chk_rd(IRQ_PEND, 32'h00, "pend_after_claim3");
        wr(IRQ_EOI, 32'd3);
        chk_rd(IRQ_INSRV, 32'h00, "insrv_eoi3");
        check1("irq_after_eoi3", IRQ, 1'b0);

        // Priority, no nesting
        SRC = 8'h24;
        ticks(4);
        check1("irq_prio", IRQ, 1'b1);
        chk_rd(IRQ_CLAIM, 32'h8000_0002, "claim2");
        ticks(4);
        check1("irq_held_insrv", IRQ, 1'b0);
        chk_rd(IRQ_PEND, 32'h20, "pend5_waiting");
        wr(IRQ_EOI, 32'd2);
        check1("irq_eoi2_edge", IRQ, 1'b0);
        tick();
        check1("irq_reassert5", IRQ, 1'b1);
        chk_rd(IRQ_CLAIM, 32'h8000_0005, "claim5");
        wr(IRQ_EOI, 32'd5);
        SRC = 8'h00;
        ticks(3);

        // Level source
        wr(IRQ_EDGE, 32'h00);
        SRC = 8'h02;
        ticks(4);
        check1("irq_level", IRQ, 1'b1);
        chk_rd(IRQ_CLAIM, 32'h8000_0001, "claim1");
        tick();
        check1("irq_level_drop", IRQ, 1'b0);
        chk_rd(IRQ_PEND, 32'h02, "pend_level_held");
        wr(IRQ_EOI, 32'd1);
        tick();
        check1("irq_level_reassert", IRQ, 1'b1);
        chk_rd(IRQ_CLAIM, 32'h8000_0001, "claim1_again");
        wr(IRQ_EOI, 32'd1);
        SRC = 8'h00;
        ticks(3);
        chk_rd(IRQ_PEND, 32'h00, "pend_level_low");

        // Collisions
        wr(IRQ_EDGE, 32'hFF);
        SRC = 8'h10;
        ticks(4);
        chk_rd(IRQ_PEND, 32'h10, "pend4_set");
        SRC = 8'h00;
        ticks(3);
        SRC = 8'h10;
        ticks(2);
        wr(IRQ_PEND, 32'h10);
        chk_rd(IRQ_PEND, 32'h10, "w1c_vs_rise");
        wr(IRQ_PEND, 32'h10);
        chk_rd(IRQ_PEND, 32'h00, "w1c_clear");
        wr(IRQ_EOI, 32'd6);
        chk_rd(IRQ_INSRV, 32'h00, "eoi_not_insrv");
        chk_rd(IRQ_CLAIM, 32'h0, "claim_empty");
        chk_rd(IRQ_INSRV, 32'h00, "claim_empty_insrv");
        check1("irq_idle", IRQ, 1'b0);

        // Mask behaviour
        SRC = 8'h00;
        ticks(3);
        wr(IRQ_MASK, 32'h00);
        SRC = 8'hFF;
        ticks(4);
        check1("irq_masked", IRQ, 1'b0);
        chk_rd(IRQ_PEND, 32'hFF, "pend_masked");
        MA  = BASE + 32'h0C;
        MOE = 1'b1;
        MWR = 1'b1;
        MWD = 32'h0;
        tick();
        MOE = 1'b0;
        MWR = 1'b0;
        chk_rd(IRQ_INSRV, 32'h00, "moe_mwr_no_claim");
        wr(IRQ_MASK, 32'h80);
        check1("irq_mask_edge", IRQ, 1'b0);
        tick();
        check1("irq_mask7", IRQ, 1'b1);
        chk_rd(IRQ_CLAIM, 32'h8000_0007, "claim7_masked_prio");
        wr(IRQ_EOI, 32'd7);

        // Reset mid-operation
        wr(IRQ_PEND, 32'hFF);
        SRC = 8'h00;
        ticks(3);
        SRC = 8'h05;
        ticks(4);
        wr(IRQ_MASK, 32'hFF);
        chk_rd(IRQ_PEND, 32'h05, "pend05");
        check1("irq_pre_reset", IRQ, 1'b1);
        #3 RESET_N = 1'b0;
        #1;
        check1("rst_async_irq", IRQ, 1'b0);
        MA  = BASE;
        MOE = 1'b1;
        #1;
        check1("rst_hit", HIT, 1'b1);
        check("rst_mid_pend", RDATA, 32'h0);
        MA = BASE + 32'h04;
        #1;
        check("rst_mid_mask", RDATA, 32'h0);
        MA = BASE + 32'h08;
        #1;
        check("rst_mid_edge", RDATA, 32'h0);
        MOE = 1'b0;
        SRC = 8'h00;
        ticks(2);
        RESET_N = 1'b1;
        tick();
        check1("irq_post_reset", IRQ, 1'b0);
        chk_rd(IRQ_PEND, 32'h00, "pend_post_reset");
        chk_rd(IRQ_INSRV, 32'h00, "insrv_post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
